// File: rtl/zigzag_rlc_pkg.sv
// rtl/zigzag_rlc_pkg.sv - shared constants, state encoding and zigzag LUT for zigzag_rlc
package zigzag_rlc_pkg;

    localparam int CW_DEF    = 11;
    localparam int RUNW_DEF  = 4;
    localparam int SIZEW_DEF = 4;
    localparam int ZRL_RUN   = 15;
    localparam int ZRL_SPAN  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DC,
        ST_SCAN,
        ST_EOB,
        ST_DRAIN
    } state_t;

    // Zigzag position -> raster index (row*8+col).
    localparam logic [5:0] ZZ_LUT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] zz_raster(input logic [5:0] k);
        return ZZ_LUT[k];
    endfunction

endpackage

// File: rtl/zigzag_rlc_vli_enc.sv
// rtl/zigzag_rlc_vli_enc.sv - combinational signed value to JPEG (size, amplitude) encoder
module zigzag_rlc_vli_enc #(
    parameter int W     = 11,
    parameter int SIZEW = 4
) (
    input  logic signed [W-1:0]     val_i,
    output logic        [SIZEW-1:0] size_o,
    output logic        [W-1:0]     amp_o
);

    logic [W-1:0] mag;
    logic [W-1:0] mask;
    logic         seen;

    always_comb begin
        mag    = val_i[W-1] ? (~val_i + 1'b1) : val_i;
        size_o = '0;
        mask   = '0;
        seen   = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            seen    = seen | mag[i];
            mask[i] = seen;
        end
        for (int i = 0; i < W; i++) begin
            if (mag[i]) begin
                size_o = SIZEW'(i + 1);
            end
        end
        // Negative values send the ones' complement of |v| over size bits.
        amp_o = val_i[W-1] ? (~mag & mask) : mag;
    end

endmodule

// File: rtl/zigzag_rlc.sv
// rtl/zigzag_rlc.sv - 8x8 block zigzag scanner and JPEG DC/AC run-length symbol generator
module zigzag_rlc
    import zigzag_rlc_pkg::*;
#(
    parameter int CW    = CW_DEF,
    parameter int RUNW  = RUNW_DEF,
    parameter int SIZEW = SIZEW_DEF
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             dc_clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [64*CW-1:0] coef_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_is_dc_o,
    output logic [RUNW-1:0]  out_run_o,
    output logic [SIZEW-1:0] out_size_o,
    output logic [CW-1:0]    out_amp_o,
    output logic             out_last_o
);

    localparam logic signed [CW+1:0] SAT_HI = (CW+2)'((1 << CW) - 1);
    localparam logic signed [CW+1:0] SAT_LO = -SAT_HI;

    state_t state_q, state_d;
    logic signed [CW-1:0] coef_q [64];
    logic [5:0]           k_q, k_d;
    logic [5:0]           run_q, run_d;
    logic signed [CW-1:0] pred_q, pred_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_is_dc_q, out_is_dc_d;
    logic [RUNW-1:0]      out_run_q, out_run_d;
    logic [SIZEW-1:0]     out_size_q, out_size_d;
    logic [CW-1:0]        out_amp_q, out_amp_d;
    logic                 out_last_q, out_last_d;

    logic                 accept;
    logic                 can_load;
    logic signed [CW-1:0] cur;
    logic signed [CW-1:0] dc_coef;
    logic signed [CW-1:0] pred_eff;
    logic signed [CW+1:0] dc_wide;
    logic signed [CW:0]   dc_diff;
    logic [SIZEW-1:0]     dc_size, ac_size;
    logic [CW:0]          dc_amp;
    logic [CW-1:0]        ac_amp;

    assign in_ready_o = (state_q == ST_IDLE);
    assign accept     = in_ready_o & in_valid_i;
    assign can_load   = ~out_valid_q | out_ready_i;
    assign cur        = coef_q[zz_raster(k_q)];

    // DC difference is formed straight from the input bus so the symbol is ready one cycle after accept.
    assign dc_coef  = coef_i[63*CW +: CW];
    assign pred_eff = dc_clear_i ? '0 : pred_q;
    assign dc_wide  = {{2{dc_coef[CW-1]}}, dc_coef} - {{2{pred_eff[CW-1]}}, pred_eff};

    always_comb begin
        if (dc_wide > SAT_HI) begin
            dc_diff = SAT_HI[CW:0];
        end else if (dc_wide < SAT_LO) begin
            dc_diff = SAT_LO[CW:0];
        end else begin
            dc_diff = dc_wide[CW:0];
        end
    end

    zigzag_rlc_vli_enc #(.W(CW + 1), .SIZEW(SIZEW)) u_dc_vli (
        .val_i  (dc_diff),
        .size_o (dc_size),
        .amp_o  (dc_amp)
    );

    zigzag_rlc_vli_enc #(.W(CW), .SIZEW(SIZEW)) u_ac_vli (
        .val_i  (cur),
        .size_o (ac_size),
        .amp_o  (ac_amp)
    );

    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int r = 0; r < 64; r++) begin
                coef_q[r] <= coef_i[(63-r)*CW +: CW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        run_d       = run_q;
        pred_d      = pred_q;
        out_valid_d = out_valid_q;
        out_is_dc_d = out_is_dc_q;
        out_run_d   = out_run_q;
        out_size_d  = out_size_q;
        out_amp_d   = out_amp_q;
        out_last_d  = out_last_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    if (dc_clear_i) begin
                        pred_d = '0;
                    end
                    out_valid_d = 1'b1;
                    out_is_dc_d = 1'b1;
                    out_run_d   = '0;
                    out_size_d  = dc_size;
                    out_amp_d   = CW'(dc_amp);
                    out_last_d  = 1'b0;
                    k_d         = '0;
                    run_d       = '0;
                    state_d     = ST_DC;
                end
            end
            ST_DC: begin
                if (out_ready_i) begin
                    pred_d      = coef_q[0];
                    k_d         = 6'd1;
                    out_valid_d = 1'b0;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (can_load) begin
                    out_valid_d = 1'b0;
                    out_is_dc_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (cur == '0) begin
                        run_d = run_q + 6'd1;
                        if (k_q == 6'd63) begin
                            state_d = ST_EOB;
                        end else begin
                            k_d = k_q + 6'd1;
                        end
                    end else if (run_q >= 6'(ZRL_SPAN)) begin
                        out_valid_d = 1'b1;
                        out_run_d   = RUNW'(ZRL_RUN);
                        out_size_d  = '0;
                        out_amp_d   = '0;
                        run_d       = run_q - 6'(ZRL_SPAN);
                    end else begin
                        out_valid_d = 1'b1;
                        out_run_d   = RUNW'(run_q);
                        out_size_d  = ac_size;
                        out_amp_d   = ac_amp;
                        out_last_d  = (k_q == 6'd63);
                        run_d       = '0;
                        if (k_q == 6'd63) begin
                            state_d = ST_DRAIN;
                        end else begin
                            k_d = k_q + 6'd1;
                        end
                    end
                end
            end
            ST_EOB: begin
                if (can_load) begin
                    out_valid_d = 1'b1;
                    out_is_dc_d = 1'b0;
                    out_run_d   = '0;
                    out_size_d  = '0;
                    out_amp_d   = '0;
                    out_last_d  = 1'b1;
                    run_d       = '0;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    k_d         = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            run_q       <= '0;
            pred_q      <= '0;
            out_valid_q <= 1'b0;
            out_is_dc_q <= 1'b0;
            out_run_q   <= '0;
            out_size_q  <= '0;
            out_amp_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            run_q       <= run_d;
            pred_q      <= pred_d;
            out_valid_q <= out_valid_d;
            out_is_dc_q <= out_is_dc_d;
            out_run_q   <= out_run_d;
            out_size_q  <= out_size_d;
            out_amp_q   <= out_amp_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_is_dc_o = out_is_dc_q;
    assign out_run_o   = out_run_q;
    assign out_size_o  = out_size_q;
    assign out_amp_o   = out_amp_q;
    assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_zigzag_rlc.sv
// tb/tb_zigzag_rlc.sv - self-checking bench for zigzag_rlc against a symbol-list reference model
module tb_zigzag_rlc;

    localparam int CW = 11;

    logic            clk = 1'b0;
    logic            srst = 1'b1;
    logic            dc_clear = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [64*CW-1:0] coef = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_is_dc;
    logic [3:0]      out_run;
    logic [3:0]      out_size;
    logic [CW-1:0]   out_amp;
    logic            out_last;

    int checks = 0;
    int failures = 0;
    int zz_order [64];
    int blk [64];
    int pred_m = 0;
    logic [20:0] exp_q [$];

    always #5 clk = ~clk;

    zigzag_rlc dut (
        .clk_i       (clk),
        .srst_i      (srst),
        .dc_clear_i  (dc_clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .coef_i      (coef),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_is_dc_o (out_is_dc),
        .out_run_o   (out_run),
        .out_size_o  (out_size),
        .out_amp_o   (out_amp),
        .out_last_o  (out_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [20:0] sym(input int dc, input int run, input int size, input int amp, input int last);
        return {dc[0], 4'(run), 4'(size), 11'(amp), last[0]};
    endfunction

    function automatic logic [20:0] dut_sym();
        return {out_is_dc, out_run, out_size, out_amp, out_last};
    endfunction

    function automatic void vli(input int v, output int sz, output int amp);
        int mag;
        mag = (v < 0) ? -v : v;
        sz = 0;
        while ((1 << sz) <= mag) sz++;
        amp = (v > 0) ? v : ((v < 0) ? v + (1 << sz) - 1 : 0);
    endfunction

    // Zigzag order built by walking anti-diagonals, alternating direction.
    task automatic build_zigzag();
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= 0 && s - r < 8; r--) begin
                    zz_order[n] = r * 8 + (s - r);
                    n++;
                end
            end else begin
                for (int r = (s < 8 ? 0 : s - 7); r < 8 && s - r >= 0; r++) begin
                    zz_order[n] = r * 8 + (s - r);
                    n++;
                end
            end
        end
    endtask

    task automatic build_expected(input bit clr);
        int diff, sz, amp, run, c;
        if (clr) pred_m = 0;
        diff = blk[0] - pred_m;
        if (diff > 2047) diff = 2047;
        if (diff < -2047) diff = -2047;
        vli(diff, sz, amp);
        exp_q.push_back(sym(1, 0, sz, amp, 0));
        pred_m = blk[0];
        run = 0;
        for (int k = 1; k < 64; k++) begin
            c = blk[zz_order[k]];
            if (c == 0) begin
                run++;
            end else begin
                while (run > 15) begin
                    exp_q.push_back(sym(0, 15, 0, 0, 0));
                    run -= 16;
                end
                vli(c, sz, amp);
                exp_q.push_back(sym(0, run, sz, amp, 0));
                run = 0;
            end
        end
        if (run > 0) exp_q.push_back(sym(0, 0, 0, 0, 0));
        exp_q[exp_q.size() - 1][0] = 1'b1;
    endtask

    task automatic clear_blk();
        for (int r = 0; r < 64; r++) blk[r] = 0;
    endtask

    task automatic send_block(input bit clr, input bit use_model);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            step();
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_wait in_ready=%0b required=1", in_ready);
        end
        for (int r = 0; r < 64; r++) coef[(63-r)*CW +: CW] = 11'(blk[r]);
        dc_clear = clr;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        dc_clear = 1'b0;
        if (use_model) build_expected(clr);
    endtask

    task automatic collect(input string name, input int ready_pct);
        int guard = 0;
        logic [20:0] e;
        while (exp_q.size() > 0 && guard < 3000) begin
            out_ready = ($urandom_range(99) < ready_pct);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (dut_sym() !== e) begin
                    failures++;
                    $display("FAIL %s_sym got=%h required=%h left=%0d", name, dut_sym(), e, exp_q.size());
                end
            end
            step();
            guard++;
        end
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout missing=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_end out_valid=%0b in_ready=%0b required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        srst = 1'b1;
        step();
        step();
        checks++;
        if ({out_valid, out_is_dc, out_run, out_size, out_amp, out_last} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", {out_valid, out_is_dc, out_run, out_size, out_amp, out_last});
        end
        srst = 1'b0;
        pred_m = 0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b required=1", in_ready);
        end
    endtask

    task automatic test_all_zero();
        clear_blk();
        send_block(1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_is_dc !== 1'b1 || out_size !== 4'd0) begin
            failures++;
            $display("FAIL zero_dc_latency valid=%0b is_dc=%0b size=%0d required 1/1/0", out_valid, out_is_dc, out_size);
        end
        collect("all_zero", 100);
    endtask

    task automatic test_dc_pred();
        clear_blk();
        blk[0] = 50;
        send_block(1'b1, 1'b1);
        collect("dc_a", 100);
        blk[0] = 45;
        send_block(1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_is_dc !== 1'b1 || out_size !== 4'd3 || out_amp !== 11'd2) begin
            failures++;
            $display("FAIL dc_diff_m5 is_dc=%0b size=%0d amp=%0d required 1/3/2", out_is_dc, out_size, out_amp);
        end
        collect("dc_b", 100);
    endtask

    task automatic test_zrl_mid();
        clear_blk();
        blk[zz_order[21]] = 3;
        send_block(1'b1, 1'b0);
        pred_m = 0;
        exp_q.push_back(sym(1, 0, 0, 0, 0));
        exp_q.push_back(sym(0, 15, 0, 0, 0));
        exp_q.push_back(sym(0, 4, 2, 3, 0));
        exp_q.push_back(sym(0, 0, 0, 0, 1));
        collect("zrl_mid", 100);
    endtask

    task automatic test_last_coef();
        clear_blk();
        blk[63] = -1;
        send_block(1'b1, 1'b0);
        pred_m = 0;
        exp_q.push_back(sym(1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) exp_q.push_back(sym(0, 15, 0, 0, 0));
        exp_q.push_back(sym(0, 14, 1, 0, 1));
        collect("last_coef", 70);
    endtask

    task automatic test_stall();
        int guard = 0;
        logic [20:0] snap, e;
        for (int r = 0; r < 64; r++) blk[r] = ($urandom_range(3) == 0) ? int'($urandom_range(200)) - 100 : 0;
        blk[zz_order[1]] = int'($urandom_range(500)) + 1;
        send_block(1'b1, 1'b1);
        out_ready = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || dut_sym() !== e) begin
            failures++;
            $display("FAIL stall_dc got=%h valid=%0b required=%h", dut_sym(), out_valid, e);
        end
        step();
        out_ready = 1'b0;
        while (!out_valid && guard < 100) begin
            step();
            guard++;
        end
        snap = dut_sym();
        for (int r = 0; r < 64; r++) coef[(63-r)*CW +: CW] = 11'($urandom);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || dut_sym() !== snap || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got=%h valid=%0b in_ready=%0b required=%h/1/0", i, dut_sym(), out_valid, in_ready, snap);
            end
        end
        in_valid = 1'b0;
        collect("stall", 60);
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_phantom out_valid=%0b required=0", out_valid);
        end
    endtask

    task automatic test_srst_mid();
        clear_blk();
        blk[0] = 20;
        blk[zz_order[30]] = 9;
        blk[zz_order[50]] = -4;
        send_block(1'b1, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        srst = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL srst_valid got=%0b required=0", out_valid);
        end
        srst = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        pred_m = 0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL srst_in_ready got=%0b required=1", in_ready);
        end
        clear_blk();
        blk[0] = 7;
        send_block(1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_is_dc !== 1'b1 || out_size !== 4'd3 || out_amp !== 11'd7) begin
            failures++;
            $display("FAIL srst_dc7 is_dc=%0b size=%0d amp=%0d required 1/3/7", out_is_dc, out_size, out_amp);
        end
        collect("srst_next", 80);
    endtask

    task automatic test_random();
        int dens;
        for (int b = 0; b < 10; b++) begin
            case ($urandom_range(3))
                0: dens = 3;
                1: dens = 15;
                2: dens = 50;
                default: dens = 100;
            endcase
            for (int r = 0; r < 64; r++)
                blk[r] = ($urandom_range(99) < dens) ? int'($urandom_range(2047)) - 1024 : 0;
            send_block($urandom_range(3) == 0, 1'b1);
            collect("random", 70);
        end
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 3; b++) begin
            clear_blk();
            blk[0] = int'($urandom_range(2047)) - 1024;
            blk[zz_order[63]] = 1023;
            blk[zz_order[$urandom_range(62) + 1]] = -1024;
            send_block(1'b0, 1'b1);
            collect("b2b", 100);
        end
    endtask

    initial begin
        build_zigzag();
        test_reset();
        test_all_zero();
        test_dc_pred();
        test_zrl_mid();
        test_last_coef();
        test_stall();
        test_srst_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
